// File: rtl/decomp_recomposer.sv
// Streaming signed-digit gadget recomposer: folds balanced decomposition digits
// (least-significant level first) back into a coefficient modulo 2^OUT_W.
module decomp_recomposer #(
  parameter int LEVEL  = 8,
  parameter int BASE_W = 2,
  parameter int OUT_W  = 21
) (
  input  logic                     clk,
  input  logic                     a_rst_n,
  input  logic signed [BASE_W:0]   in_digit,
  input  logic                     in_last,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic        [OUT_W-1:0]  out_data,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     err
);

  localparam int CNT_W   = (LEVEL > 1) ? $clog2(LEVEL) : 1;
  localparam int BASE_SH = OUT_W - LEVEL * BASE_W;

  generate
    if (LEVEL < 1 || BASE_W < 1 || OUT_W < LEVEL * BASE_W) begin : g_param_check
      $error("decomp_recomposer: need LEVEL>=1, BASE_W>=1, OUT_W>=LEVEL*BASE_W");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_vld_q, out_vld_d;
  logic             err_q, err_d;

  logic [OUT_W-1:0] digit_ext;
  logic [OUT_W-1:0] term;
  logic [OUT_W-1:0] sum;
  logic             last_level;
  logic             accept;
  int               shamt;

  assign last_level = (cnt_q == CNT_W'(LEVEL - 1));
  // Only the closing digit can stall, and only behind an undrained result.
  assign in_rdy     = !(last_level && out_vld_q && !out_rdy);
  assign accept     = in_vld && in_rdy;

  always_comb begin
    digit_ext = OUT_W'(in_digit);
    shamt     = BASE_SH + int'(cnt_q) * BASE_W;
    term      = digit_ext << shamt;
    sum       = acc_q + term;
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    err_d      = 1'b0;
    if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end
    if (accept) begin
      if (last_level) begin
        out_data_d = sum;
        out_vld_d  = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
        err_d      = !in_last;
      end else if (in_last) begin
        // Early last: drop the partial value and resynchronise the level count.
        acc_d = '0;
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      err_q      <= err_d;
    end
  end

  assign out_data = out_data_q;
  assign out_vld  = out_vld_q;
  assign err      = err_q;

endmodule
